// File: rtl/wb_pio_arbiter.sv
// Two-master Wishbone arbiter for the PIO slave: round-robin grants on CYC
// boundaries, plus a bus watchdog that turns a stalled strobe into ERR.
module wb_pio_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            resetb,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic [7:0]      timeout_cnt_o
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_ONE = WDW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic           sel_stb;
  logic           expire;

  // last_q names the master that most recently released the bus; it loses ties.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_stb = ((state_q == OWN0) && m0_stb_i) || ((state_q == OWN1) && m1_stb_i);
  // A slave ACK/ERR landing on the expiry cycle wins over the forced ERR.
  assign expire  = (TIMEOUT > 0) && sel_stb && (wd_q == WD_MAX) && !s_ack_i && !s_err_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !expire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || expire;
        m0_dat_o = s_dat_i;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !expire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || expire;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    wd_d   = '0;
    tcnt_d = tcnt_q;
    if (TIMEOUT > 0) begin
      if (expire) begin
        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
      end else if (sel_stb && !s_ack_i && !s_err_i && (state_d == state_q)) begin
        wd_d = wd_q + WD_ONE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign grant_o       = {state_q == OWN1, state_q == OWN0};
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_pio_arbiter.sv
// Directed bench for wb_pio_arbiter: bench-side masters and a registered slave
// model, with a response scoreboard popped by an independent monitor.
module tb_wb_pio_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        resetb;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i, s_err_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic [7:0]  timeout_cnt_o;

  wb_pio_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
    .wb_clk_i(wb_clk_i), .resetb(resetb),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_dat_i(s_dat_i), .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
  );

  // Clock/reset: rising edges at 5, 15, ...; bench masters drive at edge+1,
  // the slave at edge+2, masters observe at edge+3, monitor samples at edge+4.
  always #5 wb_clk_i = ~wb_clk_i;

  localparam logic [31:0] BURST_M0_ADR = 32'h3000_0200;

  logic [33:0] exp_q[$];
  logic [33:0] got, exp_v;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          bad_adr  = 0;
  int          slave_lat = 2;
  logic [31:0] slave_rdata = 32'h0;
  int          scnt = 0;
  bit          abort_m [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
    end
  endtask

  function automatic logic term(input int m);
    return (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
  endfunction

  // Driver: one CYC holding STB for 'beats' back-to-back beats.
  task automatic m_xfer(input int m, input logic we, input logic [31:0] adr, input int beats);
    logic got_t;
    @(posedge wb_clk_i); #1;
    for (int b = 0; b < beats; b++) begin
      drive(m, 1'b1, 1'b1, we, adr + 32'(4 * b), 32'hD000_0000 + 32'(b));
      got_t = 1'b0;
      for (int n = 0; n < 600 && !got_t && !abort_m[m]; n++) begin
        @(posedge wb_clk_i); #3;
        got_t = term(m);
      end
      if (abort_m[m]) break;
      if (!got_t) begin
        check("master_wait", {63'd0, got_t}, 64'd1);
        break;
      end
      @(posedge wb_clk_i); #1;
    end
    drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    for (int n = 0; n < 600 && grant_o !== g; n++) begin
      @(posedge wb_clk_i); #4;
    end
    check(name, {62'd0, grant_o}, {62'd0, g});
  endtask

  task automatic step();
    @(posedge wb_clk_i); #4;
  endtask

  // Registered slave: ACKs on the slave_lat-th strobe cycle (0 = never).
  initial begin
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = 32'h0;
    fork
      forever begin
        @(posedge wb_clk_i); #2;
        if (slave_lat != 0 && scnt == slave_lat - 1) begin
          s_ack_i = 1'b1; s_dat_i = slave_rdata;
        end else begin
          s_ack_i = 1'b0; s_dat_i = 32'h0;
        end
      end
      forever begin
        @(posedge wb_clk_i); #4;
        if (s_stb_o && !s_ack_i) scnt++;
        else scnt = 0;
      end
    join
  end

  // Monitor: pops one expected {master, err, data} per terminated beat.
  initial begin
    forever begin
      @(posedge wb_clk_i); #4;
      if (grant_o == 2'b10 && s_adr_o == BURST_M0_ADR) bad_adr++;
      if (m0_ack_o | m0_err_o | m1_ack_o | m1_err_o) begin
        check("resp_one_master", {63'd0, (m0_ack_o | m0_err_o) & (m1_ack_o | m1_err_o)}, 64'd0);
        got = (m1_ack_o | m1_err_o) ? {1'b1, m1_err_o, m1_dat_o} : {1'b0, m0_err_o, m0_dat_o};
        check("resp_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("resp_data", {30'd0, got}, {30'd0, exp_v});
        end
      end
    end
  end

  int n_stb;

  initial begin
    resetb = 1'b0;
    abort_m[0] = 1'b0; abort_m[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) step();
    check("rst_grant", {62'd0, grant_o}, 64'd0);
    check("rst_scyc", {63'd0, s_cyc_o}, 64'd0);
    check("rst_tcnt", {56'd0, timeout_cnt_o}, 64'd0);
    @(posedge wb_clk_i); #1 resetb = 1'b1;

    // m0 single read, slave answers on its 2nd strobe cycle
    slave_lat = 2; slave_rdata = 32'h0000_AB60;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_AB60});
    fork m_xfer(0, 1'b0, 32'h3000_0004, 1); join_none
    step();
    check("req_cycle_grant", {62'd0, grant_o}, 64'd0);
    check("req_cycle_stb", {63'd0, s_stb_o}, 64'd0);
    step();
    check("grant_m0", {62'd0, grant_o}, 64'd1);
    check("m0_adr", {32'd0, s_adr_o}, {32'd0, 32'h3000_0004});
    wait fork;
    step();

    // m1 alone, leaves last=1
    slave_rdata = 32'h0000_1111;
    exp_q.push_back({1'b1, 1'b0, 32'h0000_1111});
    m_xfer(1, 1'b0, 32'h3000_0010, 1);
    step();

    // tie with last=1: m0 first, then direct handover to m1
    slave_rdata = 32'h0000_2222;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_2222});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_2222});
    fork m_xfer(0, 1'b0, 32'h3000_0014, 1); m_xfer(1, 1'b0, 32'h3000_0018, 1); join_none
    wait_grant(2'b01, "tie1_first_m0");
    for (int n = 0; n < 50 && grant_o == 2'b01; n++) step();
    check("tie1_handover_no_idle", {62'd0, grant_o}, 64'd2);
    wait fork;
    step();

    // m0 alone leaves last=0, so the next tie goes to m1
    slave_rdata = 32'h0000_3333;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_3333});
    m_xfer(0, 1'b0, 32'h3000_0020, 1);
    step();
    exp_q.push_back({1'b1, 1'b0, 32'h0000_3333});
    exp_q.push_back({1'b0, 1'b0, 32'h0000_3333});
    fork m_xfer(0, 1'b0, 32'h3000_0024, 1); m_xfer(1, 1'b0, 32'h3000_0028, 1); join_none
    wait_grant(2'b10, "tie2_first_m1");
    wait fork;
    step();

    // m1 4-beat write burst; m0 requests mid-burst and must wait
    slave_rdata = 32'h0000_4444;
    bad_adr = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'b0, 32'h0000_4444});
    exp_q.push_back({1'b0, 1'b0, 32'h0000_4444});
    fork m_xfer(1, 1'b1, 32'h3000_0100, 4); join_none
    wait_grant(2'b10, "burst_grant_m1");
    check("burst_we", {63'd0, s_we_o}, 64'd1);
    check("burst_wdata", {32'd0, s_dat_o}, {32'd0, 32'hD000_0000});
    fork m_xfer(0, 1'b0, BURST_M0_ADR, 1); join_none
    wait fork;
    check("burst_no_m0_adr", 64'(bad_adr), 64'd0);
    step();

    // watchdog: slave never answers m0; m1 waits and is served after the ERR
    slave_lat = 0; slave_rdata = 32'h0000_5555;
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_5555});
    fork m_xfer(0, 1'b0, 32'h3000_0300, 1); join_none
    wait_grant(2'b01, "to_grant_m0");
    fork m_xfer(1, 1'b0, 32'h3000_0304, 1); join_none
    n_stb = 0;
    for (int n = 0; n < 400 && !m0_err_o; n++) begin
      if (s_stb_o) n_stb++;
      step();
    end
    check("to_strobe_cycles", 64'(n_stb), 64'd255);
    slave_lat = 2;
    wait_grant(2'b10, "to_then_m1");
    check("to_count_one", {56'd0, timeout_cnt_o}, 64'd1);
    wait fork;
    step();

    // slave ACK on exactly the expiry cycle: ACK wins, count unchanged
    slave_lat = 256; slave_rdata = 32'h0000_6666;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_6666});
    m_xfer(0, 1'b0, 32'h3000_0400, 1);
    step();
    check("ack_wins_count", {56'd0, timeout_cnt_o}, 64'd1);

    // async reset in the middle of an m1 burst beat
    slave_lat = 3; slave_rdata = 32'h0000_7777;
    fork m_xfer(1, 1'b1, 32'h3000_0500, 4); join_none
    wait_grant(2'b10, "rstmid_grant_m1");
    step();
    #2 resetb = 1'b0;
    abort_m[1] = 1'b1;
    #1;
    check("rstmid_grant", {62'd0, grant_o}, 64'd0);
    check("rstmid_scyc", {63'd0, s_cyc_o}, 64'd0);
    check("rstmid_sstb", {63'd0, s_stb_o}, 64'd0);
    check("rstmid_tcnt", {56'd0, timeout_cnt_o}, 64'd0);
    wait fork;
    repeat (2) @(posedge wb_clk_i);
    #1 resetb = 1'b1;
    abort_m[1] = 1'b0;

    // first tie after reset goes to m0
    slave_lat = 2;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_7777});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_7777});
    fork m_xfer(0, 1'b0, 32'h3000_0600, 1); m_xfer(1, 1'b0, 32'h3000_0604, 1); join_none
    step();
    check("post_rst_req_cycle", {62'd0, grant_o}, 64'd0);
    step();
    check("post_rst_grant_m0", {62'd0, grant_o}, 64'd1);
    wait fork;

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
